// File: rtl/memory_arbiter.sv
// Two-requester (fetch / data) arbiter in front of a single-ported memory.
// Define MEMORY_ARBITER_ROUND_ROBIN_EN for alternating grants; default is fixed data priority.
module memory_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              fetch_flush,
    output logic [DATA_W-1:0] fetch_rdata,
    output logic              fetch_ready,
    input  logic              data_req,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic              data_we,
    input  logic [DATA_W-1:0] data_wdata,
    input  logic [1:0]        data_mask,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_ready,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [1:0]        mem_mask,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    typedef logic [1:0] memory_mask_t;
    localparam memory_mask_t MEM_WORD = 2'b10;

    typedef enum logic [1:0] {IDLE, BUSY_F, BUSY_D, RESP} state_t;

    state_t              state_q, state_d;
    logic                gnt_fetch_q, gnt_fetch_d;
    logic                flush_q, flush_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    memory_mask_t        mask_q, mask_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   fetch_rdata_q, fetch_rdata_d;
    logic [DATA_W-1:0]   data_rdata_q, data_rdata_d;
    logic                pick_fetch;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
    logic                last_fetch_q, last_fetch_d;
`endif

    always_comb begin
        state_d       = state_q;
        gnt_fetch_d   = gnt_fetch_q;
        flush_d       = flush_q;
        addr_d        = addr_q;
        we_d          = we_q;
        mask_d        = mask_q;
        wdata_d       = wdata_q;
        fetch_rdata_d = fetch_rdata_q;
        data_rdata_d  = data_rdata_q;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
        last_fetch_d  = last_fetch_q;
        pick_fetch    = fetch_req && (!data_req || !last_fetch_q);
`else
        pick_fetch    = fetch_req && !data_req;
`endif
        case (state_q)
            IDLE: begin
                if (fetch_req || data_req) begin
                    gnt_fetch_d = pick_fetch;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
                    last_fetch_d = pick_fetch;
`endif
                    if (pick_fetch) begin
                        addr_d  = fetch_addr;
                        we_d    = 1'b0;
                        mask_d  = MEM_WORD;
                        wdata_d = '0;
                        flush_d = fetch_flush;
                        state_d = BUSY_F;
                    end else begin
                        addr_d  = data_addr;
                        we_d    = data_we;
                        mask_d  = (data_mask == 2'b11) ? MEM_WORD : data_mask;
                        wdata_d = data_wdata;
                        flush_d = 1'b0;
                        state_d = BUSY_D;
                    end
                end
            end
            BUSY_F: begin
                // A redirect anywhere in the transaction drops the result but lets memory finish.
                if (fetch_flush) flush_d = 1'b1;
                if (mem_ack) begin
                    if (!(flush_q || fetch_flush)) fetch_rdata_d = mem_rdata;
                    state_d = RESP;
                end
            end
            BUSY_D: begin
                if (mem_ack) begin
                    data_rdata_d = we_q ? '0 : mem_rdata;
                    state_d      = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            gnt_fetch_q   <= 1'b0;
            flush_q       <= 1'b0;
            addr_q        <= '0;
            we_q          <= 1'b0;
            mask_q        <= '0;
            wdata_q       <= '0;
            fetch_rdata_q <= '0;
            data_rdata_q  <= '0;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
            last_fetch_q  <= 1'b1;
`endif
        end else begin
            state_q       <= state_d;
            gnt_fetch_q   <= gnt_fetch_d;
            flush_q       <= flush_d;
            addr_q        <= addr_d;
            we_q          <= we_d;
            mask_q        <= mask_d;
            wdata_q       <= wdata_d;
            fetch_rdata_q <= fetch_rdata_d;
            data_rdata_q  <= data_rdata_d;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
            last_fetch_q  <= last_fetch_d;
`endif
        end
    end

    assign mem_req     = (state_q == BUSY_F) || (state_q == BUSY_D);
    assign mem_addr    = addr_q;
    assign mem_we      = we_q;
    assign mem_mask    = mask_q;
    assign mem_wdata   = wdata_q;
    assign fetch_ready = (state_q == RESP) && gnt_fetch_q && !flush_q;
    assign data_ready  = (state_q == RESP) && !gnt_fetch_q;
    assign fetch_rdata = fetch_rdata_q;
    assign data_rdata  = data_rdata_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: scoreboarded ready pulses plus cycle-level mem_* checks.
module tb_memory_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_req, fetch_flush, fetch_ready;
    logic [31:0] fetch_addr, fetch_rdata;
    logic        data_req, data_we, data_ready;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [1:0]  data_mask;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  mem_mask;

    typedef struct packed {
        logic        is_fetch;
        logic [31:0] data;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] order_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          ack_delay = 0;
    int          wcnt = 0;
    logic        resp_en = 1'b1;
    logic        stray_ack = 1'b0;

    memory_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_flush(fetch_flush),
        .fetch_rdata(fetch_rdata), .fetch_ready(fetch_ready),
        .data_req(data_req), .data_addr(data_addr), .data_we(data_we),
        .data_wdata(data_wdata), .data_mask(data_mask),
        .data_rdata(data_rdata), .data_ready(data_ready),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_mask(mem_mask),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Memory responder: acks after ack_delay wait cycles, logs the address of each completion.
    always @(posedge clk) begin
        #2;
        mem_ack = 1'b0;
        if (stray_ack) begin
            mem_ack = 1'b1;
        end else if (mem_req && resp_en) begin
            if (wcnt == ack_delay) begin
                mem_ack = 1'b1;
                order_q.push_back(mem_addr);
                wcnt = 0;
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
    end

    // Every ready pulse must match the oldest expected completion.
    always @(negedge clk) begin
        if (fetch_ready || data_ready) begin
            if (sb_q.size() == 0) begin
                chk("spurious_ready", {31'b0, fetch_ready, data_ready}, 64'h0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("ready_port", {fetch_ready, data_ready}, {e.is_fetch, ~e.is_fetch});
                chk("ready_rdata", fetch_ready ? fetch_rdata : data_rdata, e.data);
            end
        end
    end

    initial begin
        int   n;
        exp_t e;
        logic [31:0] exp_addr[4];
        rst_n = 1'b0; fetch_req = 1'b0; fetch_flush = 1'b0; fetch_addr = '0;
        data_req = 1'b0; data_we = 1'b0; data_addr = '0; data_wdata = '0; data_mask = '0;
        mem_rdata = '0; mem_ack = 1'b0;

        // Reset state
        step(); step();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_mask", mem_mask, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_fetch_ready", fetch_ready, 0);
        chk("rst_data_ready", data_ready, 0);
        chk("rst_fetch_rdata", fetch_rdata, 0);
        chk("rst_data_rdata", data_rdata, 0);
        rst_n = 1'b1;
        step();

        // Minimum-latency fetch
        ack_delay = 0; mem_rdata = 32'h0000_0013;
        fetch_req = 1'b1; fetch_addr = 32'h0000_0010;
        e.is_fetch = 1'b1; e.data = 32'h0000_0013; sb_q.push_back(e);
        step();
        chk("f_mem_req_c1", mem_req, 1);
        chk("f_mem_addr", mem_addr, 32'h10);
        chk("f_mem_mask", mem_mask, 2'b10);
        chk("f_mem_we", mem_we, 0);
        step();
        chk("f_ready_c2", fetch_ready, 1);
        chk("f_rdata", fetch_rdata, 32'h13);
        chk("f_mem_req_resp", mem_req, 0);
        fetch_req = 1'b0;
        step();
        chk("f_ready_c3", fetch_ready, 0);

        // Data read with mask 2'b11 forwarded as word
        ack_delay = 1; mem_rdata = 32'h5555_AAAA;
        data_req = 1'b1; data_we = 1'b0; data_addr = 32'h0000_0203; data_mask = 2'b11;
        e.is_fetch = 1'b0; e.data = 32'h5555_AAAA; sb_q.push_back(e);
        step();
        chk("dr_mem_mask", mem_mask, 2'b10);
        chk("dr_mem_addr", mem_addr, 32'h203);
        chk("dr_mem_we", mem_we, 0);
        step(); step();
        chk("dr_ready", data_ready, 1);
        chk("dr_rdata", data_rdata, 32'h5555_AAAA);
        data_req = 1'b0;
        step();

        // Data write with 3 wait cycles; inputs disturbed mid-transaction
        ack_delay = 3; mem_rdata = 32'hFFFF_FFFF;
        data_req = 1'b1; data_we = 1'b1; data_addr = 32'h100;
        data_wdata = 32'hDEAD_BEEF; data_mask = 2'b00;
        e.is_fetch = 1'b0; e.data = 32'h0; sb_q.push_back(e);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("dw_mem_req", mem_req, 1);
            chk("dw_mem_addr", mem_addr, 32'h100);
            chk("dw_mem_we", mem_we, 1);
            chk("dw_mem_mask", mem_mask, 2'b00);
            chk("dw_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
            chk("dw_no_ready", data_ready, 0);
            if (i == 0) begin
                data_addr = 32'h999; data_wdata = 32'h0; data_we = 1'b0; data_mask = 2'b01;
            end
        end
        step();
        chk("dw_ready", data_ready, 1);
        chk("dw_rdata_zero", data_rdata, 0);
        data_req = 1'b0;
        step();
        chk("dw_ready_once", data_ready, 0);

        // Flush in the same cycle as the fetch grant
        ack_delay = 0; mem_rdata = 32'hFFFF_0000;
        fetch_req = 1'b1; fetch_flush = 1'b1; fetch_addr = 32'h20;
        step();
        fetch_req = 1'b0; fetch_flush = 1'b0;
        chk("fg_mem_req", mem_req, 1);
        step();
        chk("fg_no_ready", fetch_ready, 0);
        chk("fg_rdata_kept", fetch_rdata, 32'h13);
        step();

        // Flush while BUSY_F, then a normal fetch
        ack_delay = 2; mem_rdata = 32'h1234_5678;
        fetch_req = 1'b1; fetch_addr = 32'h24;
        step();
        fetch_flush = 1'b1;
        step();
        fetch_flush = 1'b0; fetch_req = 1'b0;
        chk("fb_mem_req_held", mem_req, 1);
        chk("fb_mem_addr_held", mem_addr, 32'h24);
        step(); step();
        chk("fb_no_ready", fetch_ready, 0);
        chk("fb_rdata_kept", fetch_rdata, 32'h13);
        step();
        ack_delay = 0; mem_rdata = 32'h0000_0077;
        fetch_req = 1'b1; fetch_addr = 32'h30;
        e.is_fetch = 1'b1; e.data = 32'h77; sb_q.push_back(e);
        step(); step();
        chk("fn_ready", fetch_ready, 1);
        chk("fn_rdata", fetch_rdata, 32'h77);
        fetch_req = 1'b0;
        step();

        // Reset in BUSY_D, stray ack afterwards
        resp_en = 1'b0;
        data_req = 1'b1; data_we = 1'b0; data_addr = 32'h300; data_mask = 2'b10;
        step();
        chk("rb_mem_req", mem_req, 1);
        step();
        rst_n = 1'b0;
        step();
        chk("rb_mem_req_rst", mem_req, 0);
        chk("rb_fetch_rdata_rst", fetch_rdata, 0);
        rst_n = 1'b1; data_req = 1'b0;
        step();
        stray_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        step();
        stray_ack = 1'b0;
        chk("rb_mem_req_stray", mem_req, 0);
        chk("rb_no_ready", data_ready, 0);
        step();
        chk("rb_mem_req_after", mem_req, 0);
        chk("rb_data_rdata", data_rdata, 0);

        // Both requesters held for four transactions
        resp_en = 1'b1; ack_delay = 0; mem_rdata = 32'h0BAD_F00D;
        order_q.delete();
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
        exp_addr = '{32'h80, 32'h40, 32'h80, 32'h40};
`else
        exp_addr = '{32'h80, 32'h80, 32'h80, 32'h80};
`endif
        for (int i = 0; i < 4; i++) begin
            e.is_fetch = (exp_addr[i] == 32'h40); e.data = 32'h0BAD_F00D; sb_q.push_back(e);
        end
        fetch_req = 1'b1; fetch_addr = 32'h40;
        data_req = 1'b1; data_addr = 32'h80; data_we = 1'b0; data_mask = 2'b10;
        n = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            step();
            if (fetch_ready || data_ready) n++;
        end
        fetch_req = 1'b0; data_req = 1'b0;
        chk("arb_completions", n, 4);
        step(); step(); step();
        chk("arb_count", order_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("arb_order%0d", i), (order_q.size() > i) ? order_q[i] : 32'hX, exp_addr[i]);
        end

        chk("sb_drained", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
